// File: rtl/press_classifier.sv
// Button gesture classifier: turns debounced press/release edge pulses into
// short, long, auto-repeat and double press strobes plus a held level.
module press_classifier #(
   parameter logic [31:0] LONG_PRESS_COUNT = 32'd25000000,
   parameter logic [31:0] DOUBLE_GAP_COUNT = 32'd12500000,
   parameter logic [31:0] REPEAT_COUNT     = 32'd5000000
) (
   input  logic clk,
   input  logic reset_b,
   input  logic press_pulse,
   input  logic release_pulse,
   output logic short_press,
   output logic long_press,
   output logic repeat_press,
   output logic double_press,
   output logic held
);

   localparam int unsigned CNT_W = 32;

   localparam logic [CNT_W-1:0] LONG_LAST   = LONG_PRESS_COUNT - 32'd1;
   localparam logic [CNT_W-1:0] GAP_LAST    = DOUBLE_GAP_COUNT - 32'd1;
   localparam logic [CNT_W-1:0] REPEAT_LAST = REPEAT_COUNT - 32'd1;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      PRESSED   = 3'd1,
      LONG_HELD = 3'd2,
      WAIT_GAP  = 3'd3,
      SECOND    = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic             short_d, long_d, repeat_d, double_d, held_d;

   assign cnt_inc = cnt_q + CNT_W'(1);

   // Next state, counter and strobe decisions; an accepted edge always
   // takes priority over a threshold reached in the same cycle.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_inc;
      short_d  = 1'b0;
      long_d   = 1'b0;
      repeat_d = 1'b0;
      double_d = 1'b0;

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (press_pulse) begin
               state_d = PRESSED;
            end
         end
         PRESSED: begin
            if (release_pulse) begin
               state_d = WAIT_GAP;
               cnt_d   = '0;
            end else if (cnt_q == LONG_LAST) begin
               state_d = LONG_HELD;
               cnt_d   = '0;
               long_d  = 1'b1;
            end
         end
         LONG_HELD: begin
            if (release_pulse) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == REPEAT_LAST) begin
               cnt_d    = '0;
               repeat_d = 1'b1;
            end
         end
         WAIT_GAP: begin
            if (press_pulse) begin
               state_d = SECOND;
               cnt_d   = '0;
            end else if (cnt_q == GAP_LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
               short_d = 1'b1;
            end
         end
         SECOND: begin
            if (release_pulse) begin
               state_d  = IDLE;
               cnt_d    = '0;
               double_d = 1'b1;
            end else if (cnt_q == '1) begin
               cnt_d = cnt_q;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      held_d = (state_d == PRESSED) || (state_d == LONG_HELD) || (state_d == SECOND);
   end

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         short_press  <= 1'b0;
         long_press   <= 1'b0;
         repeat_press <= 1'b0;
         double_press <= 1'b0;
         held         <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         short_press  <= short_d;
         long_press   <= long_d;
         repeat_press <= repeat_d;
         double_press <= double_d;
         held         <= held_d;
      end
   end

endmodule

// File: tb/tb_press_classifier.sv
// Bench for press_classifier: directed gesture scenarios with fixed expected
// strobe cycles, then random pulses checked cycle-by-cycle against a gesture model.
module tb_press_classifier;

   localparam int L = 8;
   localparam int G = 5;
   localparam int R = 4;

   logic clk = 1'b0;
   logic reset_b = 1'b0;
   logic press_pulse = 1'b0;
   logic release_pulse = 1'b0;
   logic short_press, long_press, repeat_press, double_press, held;

   always #5 clk = ~clk;

   press_classifier #(
      .LONG_PRESS_COUNT(32'(L)),
      .DOUBLE_GAP_COUNT(32'(G)),
      .REPEAT_COUNT    (32'(R))
   ) dut (
      .clk          (clk),
      .reset_b      (reset_b),
      .press_pulse  (press_pulse),
      .release_pulse(release_pulse),
      .short_press  (short_press),
      .long_press   (long_press),
      .repeat_press (repeat_press),
      .double_press (double_press),
      .held         (held)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Gesture model: phase 0 up, 1 down, 2 long hold, 3 released gap, 4 second press
   int         m_phase = 0;
   int         m_entry = 0;
   logic [4:0] m_out = '0;
   int         t = 0;

   int s_cnt[4], s_first[4], s_last[4];
   int held_first, held_last;
   logic [63:0] pm, rm, rstm;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0d)", tag, obs, exp, t);
      end
   endtask

   task automatic model_step(input logic p, input logic r, input logic rb);
      int   el;
      logic s, l, rp, d;
      s = 1'b0; l = 1'b0; rp = 1'b0; d = 1'b0;
      el = t - m_entry;
      if (!rb) begin
         m_phase = 0;
      end else begin
         case (m_phase)
            0: if (p) begin m_phase = 1; m_entry = t + 1; end
            1: if (r) begin m_phase = 3; m_entry = t + 1; end
               else if (el == L - 1) begin m_phase = 2; m_entry = t + 1; l = 1'b1; end
            2: if (r) m_phase = 0;
               else if (el % R == R - 1) rp = 1'b1;
            3: if (p) begin m_phase = 4; m_entry = t + 1; end
               else if (el == G - 1) begin m_phase = 0; s = 1'b1; end
            4: if (r) begin m_phase = 0; d = 1'b1; end
            default: m_phase = 0;
         endcase
      end
      m_out = {s, l, rp, d, (m_phase == 1 || m_phase == 2 || m_phase == 4)};
   endtask

   // Drive one cycle of inputs, advance the model, check the registered outputs.
   task automatic step(input logic p, input logic r, input logic rb);
      logic [3:0] o;
      @(negedge clk);
      reset_b       = rb;
      press_pulse   = p;
      release_pulse = r;
      if (!rb) begin
         #1;
         check("async_rst", 32'({short_press, long_press, repeat_press, double_press, held}), 32'd0);
      end
      model_step(p, r, rb);
      @(posedge clk);
      #1;
      check("outputs", 32'({short_press, long_press, repeat_press, double_press, held}), 32'(m_out));
      o = {double_press, repeat_press, long_press, short_press};
      for (int i = 0; i < 4; i++) begin
         if (o[i]) begin
            if (s_cnt[i] == 0) s_first[i] = t + 1;
            s_last[i] = t + 1;
            s_cnt[i]++;
         end
      end
      if (held) begin
         if (held_first < 0) held_first = t + 1;
         held_last = t + 1;
      end
      t++;
   endtask

   task automatic run_scn(input int nc);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         s_cnt[i] = 0; s_first[i] = -1; s_last[i] = -1;
      end
      held_first = -1;
      held_last  = -1;
      t = 0;
      for (int c = 0; c < nc; c++) step(pm[c], rm[c], !rstm[c]);
   endtask

   task automatic check_strobe(input string tag, input int idx, input int cnt,
                               input int first, input int last);
      check({tag, "_count"}, 32'(s_cnt[idx]), 32'(cnt));
      if (cnt > 0) begin
         check({tag, "_first"}, 32'(s_first[idx]), 32'(first));
         check({tag, "_last"}, 32'(s_last[idx]), 32'(last));
      end
   endtask

   initial begin
      // short press
      pm = '0; rm = '0; rstm = '0;
      pm[10] = 1'b1; rm[13] = 1'b1;
      run_scn(40);
      check_strobe("short_s", 0, 1, 19, 19);
      check_strobe("short_l", 1, 0, 0, 0);
      check_strobe("short_d", 3, 0, 0, 0);
      check("short_held_first", 32'(held_first), 32'd11);
      check("short_held_last", 32'(held_last), 32'd13);

      // long press with auto-repeat; release on a repeat point suppresses it
      pm = '0; rm = '0; rstm = '0;
      pm[10] = 1'b1; rm[30] = 1'b1;
      run_scn(45);
      check_strobe("long_l", 1, 1, 19, 19);
      check_strobe("long_r", 2, 2, 23, 27);
      check_strobe("long_s", 0, 0, 0, 0);
      check("long_held_last", 32'(held_last), 32'd30);

      // double press
      pm = '0; rm = '0; rstm = '0;
      pm[10] = 1'b1; rm[12] = 1'b1; pm[15] = 1'b1; rm[17] = 1'b1;
      run_scn(40);
      check_strobe("dbl_d", 3, 1, 18, 18);
      check_strobe("dbl_s", 0, 0, 0, 0);

      // release exactly at the long threshold
      pm = '0; rm = '0; rstm = '0;
      pm[10] = 1'b1; rm[18] = 1'b1;
      run_scn(40);
      check_strobe("bl_s", 0, 1, 24, 24);
      check_strobe("bl_l", 1, 0, 0, 0);

      // second press exactly at the gap threshold
      pm = '0; rm = '0; rstm = '0;
      pm[10] = 1'b1; rm[12] = 1'b1; pm[17] = 1'b1; rm[19] = 1'b1;
      run_scn(40);
      check_strobe("bg_d", 3, 1, 20, 20);
      check_strobe("bg_s", 0, 0, 0, 0);

      // reset during a long hold discards the gesture; pulses in reset ignored
      pm = '0; rm = '0; rstm = '0;
      pm[10] = 1'b1; rstm[21] = 1'b1; rstm[22] = 1'b1; pm[22] = 1'b1; rm[25] = 1'b1;
      run_scn(45);
      check_strobe("rst_l", 1, 1, 19, 19);
      check_strobe("rst_r", 2, 0, 0, 0);
      check_strobe("rst_s", 0, 0, 0, 0);
      check_strobe("rst_d", 3, 0, 0, 0);

      // stray pulses: release in idle, press+release together, repeated press
      pm = '0; rm = '0; rstm = '0;
      rm[5] = 1'b1; pm[10] = 1'b1; rm[10] = 1'b1; pm[12] = 1'b1; rm[13] = 1'b1;
      run_scn(40);
      check_strobe("ign_s", 0, 1, 19, 19);
      check_strobe("ign_l", 1, 0, 0, 0);
      check("ign_held_first", 32'(held_first), 32'd11);
      check("ign_held_last", 32'(held_last), 32'd13);

      // random pulses, occasional resets, checked every cycle
      for (int c = 0; c < 4000; c++) begin
         step($urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
              !($urandom_range(0, 299) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
